// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped 8N1 UART transmitter with byte FIFO
//
// Purpose: sits on the processor data-memory bus beside the data memory,
// queues bytes stored to TXDATA in a small FIFO and shifts them out as
// 8N1 frames (start bit, 8 data bits LSB first, stop bit).
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low reset
//   A      data-bus address (word decode on A[31:2])
//   WD     data-bus write data
//   WE     data-bus write enable
//   RD     register read data, combinational from A and internal state
//   tx     serial output, idle high
//   busy   FIFO non-empty or frame in progress
module uart_tx_mmio #(
   parameter int          CLKS_PER_BIT = 434,
   parameter int          FIFO_DEPTH   = 8,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0400
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] A,
   input  logic [31:0] WD,
   input  logic        WE,
   output logic [31:0] RD,
   output logic        tx,
   output logic        busy
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);
   localparam logic [29:0]   DATA_WORD  = BASE_ADDR[31:2];
   localparam logic [29:0]   STAT_WORD  = BASE_ADDR[31:2] + 30'd1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} stateType;

   stateType       state, stateNext;
   logic [BW-1:0]  baudCnt, baudNext;
   logic [2:0]     bitIdx, bitIdxNext;
   logic [7:0]     shiftReg, shiftNext;

   logic [7:0]     fifoMem [FIFO_DEPTH];
   logic [PW-1:0]  wrPtr, rdPtr;
   logic [CW-1:0]  count;
   logic           overflow;

   logic empty, full, selData, selStat;
   logic push, pushOk, pop, ovfSet, ovfClr;
   logic unusedBits;

   assign unusedBits = ^{A[1:0], WD[31:8]};

   assign empty   = (count == '0);
   assign full    = (count == COUNT_FULL);
   assign selData = (A[31:2] == DATA_WORD);
   assign selStat = (A[31:2] == STAT_WORD);

   // A push into a full FIFO is dropped even if the transmitter pops in
   // the same cycle: fullness is judged on the pre-edge count.
   assign push   = WE & selData;
   assign pushOk = push & ~full;
   assign pop    = (state == IDLE) & ~empty;
   assign ovfSet = push & full;
   assign ovfClr = WE & selStat & WD[3];

   assign busy = (state != IDLE) | ~empty;
   assign RD   = selStat ? {28'b0, overflow, busy, full, empty} : 32'b0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wrPtr    <= '0;
         rdPtr    <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (pushOk) wrPtr <= wrPtr + PW'(1);
         if (pop)    rdPtr <= rdPtr + PW'(1);
         case ({pushOk, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         // set has priority over a simultaneous clear
         if (ovfSet)      overflow <= 1'b1;
         else if (ovfClr) overflow <= 1'b0;
      end
   end

   // Storage needs no reset: entries are only read once counted valid.
   always_ff @(posedge clk) begin
      if (pushOk) fifoMem[wrPtr] <= WD[7:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         baudCnt  <= '0;
         bitIdx   <= '0;
         shiftReg <= '0;
      end else begin
         state    <= stateNext;
         baudCnt  <= baudNext;
         bitIdx   <= bitIdxNext;
         shiftReg <= shiftNext;
      end
   end

   always_comb begin
      stateNext  = state;
      baudNext   = baudCnt + BW'(1);
      bitIdxNext = bitIdx;
      shiftNext  = shiftReg;
      case (state)
         IDLE: begin
            baudNext = '0;
            if (!empty) begin
               stateNext  = START;
               shiftNext  = fifoMem[rdPtr];
               bitIdxNext = '0;
            end
         end
         START: begin
            if (baudCnt == BAUD_LAST) begin
               stateNext = DATA;
               baudNext  = '0;
            end
         end
         DATA: begin
            if (baudCnt == BAUD_LAST) begin
               baudNext  = '0;
               shiftNext = {1'b0, shiftReg[7:1]};
               if (bitIdx == 3'd7) stateNext  = STOP;
               else                bitIdxNext = bitIdx + 3'd1;
            end
         end
         STOP: begin
            // always return through IDLE: gives one idle-high cycle between frames
            if (baudCnt == BAUD_LAST) begin
               stateNext = IDLE;
               baudNext  = '0;
            end
         end
         default: begin
            stateNext = IDLE;
            baudNext  = '0;
         end
      endcase
   end

   always_comb begin
      tx = 1'b1;
      case (state)
         IDLE:    tx = 1'b1;
         START:   tx = 1'b0;
         DATA:    tx = shiftReg[0];
         STOP:    tx = 1'b1;
         default: tx = 1'b1;
      endcase
   end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - self-checking bench for uart_tx_mmio
module tb_uart_tx_mmio;
   localparam int          C    = 4;
   localparam int          D    = 8;
   localparam logic [31:0] BASE = 32'h0000_0400;
   localparam logic [29:0] DATA_W = BASE[31:2];
   localparam logic [29:0] STAT_W = BASE[31:2] + 30'd1;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] A = '0;
   logic [31:0] WD = '0;
   logic        WE = 1'b0;
   logic [31:0] RD;
   logic        tx;
   logic        busy;

   uart_tx_mmio #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D), .BASE_ADDR(BASE)) dut (
      .clk(clk), .reset(reset), .A(A), .WD(WD), .WE(WE),
      .RD(RD), .tx(tx), .busy(busy)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: a byte queue plus a line that is occupied for 10*C
   // cycles per frame and can accept the next byte one cycle after that.
   logic [7:0] q[$];
   logic       ovf;
   int         e;
   int         nextPop;
   int         frameStart;
   logic       frameValid;
   logic [7:0] frameByte;

   task automatic modelReset();
      q.delete();
      ovf        = 1'b0;
      frameValid = 1'b0;
      nextPop    = 0;
   endtask

   task automatic modelStep(input logic [31:0] a, input logic [31:0] wd, input logic we);
      logic popNow, fullBefore;
      e++;
      popNow     = (e >= nextPop) && (q.size() > 0);
      fullBefore = (q.size() == D);
      if (popNow) begin
         frameByte  = q.pop_front();
         frameStart = e;
         frameValid = 1'b1;
         nextPop    = e + 10 * C + 1;
      end
      if (we && a[31:2] == DATA_W) begin
         if (fullBefore) ovf = 1'b1;
         else            q.push_back(wd[7:0]);
      end else if (we && a[31:2] == STAT_W && wd[3]) begin
         ovf = 1'b0;
      end
   endtask

   function automatic logic frameActive();
      return frameValid && ((e - frameStart) < 10 * C);
   endfunction

   function automatic logic expTx();
      int k;
      if (!frameActive()) return 1'b1;
      k = (e - frameStart) / C;
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return frameByte[k-1];
   endfunction

   function automatic logic expBusy();
      return frameActive() || (q.size() != 0);
   endfunction

   function automatic logic [31:0] expRd(input logic [31:0] a);
      if (a[31:2] == STAT_W)
         return {28'b0, ovf, expBusy(), (q.size() == D), (q.size() == 0)};
      return 32'b0;
   endfunction

   function automatic logic [31:0] randAddr();
      case ($urandom_range(0, 5))
         0:       return 32'h400;
         1:       return 32'h404;
         2:       return 32'h402;
         3:       return 32'h407;
         4:       return 32'h500;
         default: return $urandom;
      endcase
   endfunction

   // Called at a negedge: drive the bus, check RD, take the edge, check outputs.
   task automatic busCycle(input logic [31:0] a, input logic [31:0] wd, input logic we);
      A = a; WD = wd; WE = we;
      #1;
      checkVal("rd", RD, expRd(a));
      @(posedge clk);
      if (reset) modelStep(a, wd, we);
      @(negedge clk);
      checkVal("tx", {31'b0, tx}, {31'b0, expTx()});
      checkVal("busy", {31'b0, busy}, {31'b0, expBusy()});
   endtask

   task automatic idle();
      busCycle(randAddr(), $urandom, 1'b0);
   endtask

   task automatic readStatus(input string tag, input logic [31:0] exp);
      A = 32'h404; WE = 1'b0;
      #1;
      checkVal(tag, RD, exp);
   endtask

   logic [9:0] a5Bits;
   logic [9:0] b2b;

   initial begin
      e = 0;
      frameStart = 0;
      frameByte = '0;
      modelReset();
      reset = 1'b0;
      @(negedge clk);

      // reset with bus activity
      repeat (3) busCycle(randAddr(), $urandom, 1'($urandom));
      checkVal("rst_tx", {31'b0, tx}, 32'h1);
      checkVal("rst_busy", {31'b0, busy}, 32'h0);
      readStatus("rst_status", 32'h1);
      reset = 1'b1;
      idle();

      // single byte 0xA5
      a5Bits = {1'b1, 8'hA5, 1'b0};
      busCycle(32'h400, 32'hFFFF_FFA5, 1'b1);
      for (int i = 0; i < 40; i++) begin
         idle();
         checkVal("a5_frame", {31'b0, tx}, {31'b0, a5Bits[i/4]});
      end
      checkVal("a5_busy_hold", {31'b0, busy}, 32'h1);
      idle();
      checkVal("a5_busy_drop", {31'b0, busy}, 32'h0);

      // overflow
      for (int i = 1; i <= 10; i++) busCycle(32'h400, i, 1'b1);
      readStatus("ovf_status", 32'hE);
      repeat (9 * 41 + 10) idle();
      readStatus("ovf_sticky", 32'h9);
      busCycle(32'h404, 32'h8, 1'b1);
      readStatus("ovf_clear", 32'h1);

      // back-to-back 0x00 then 0xFF
      busCycle(32'h400, 32'h00, 1'b1);
      busCycle(32'h400, 32'hFF, 1'b1);
      for (int j = 1; j <= 85; j++) begin
         idle();
         if (j >= 38 && j <= 41) b2b[j-38] = tx;
      end
      checkVal("b2b_stop", {31'b0, b2b[0]}, 32'h1);
      checkVal("b2b_stop_end", {31'b0, b2b[1]}, 32'h1);
      checkVal("b2b_idle", {31'b0, b2b[2]}, 32'h1);
      checkVal("b2b_start2", {31'b0, b2b[3]}, 32'h0);

      // decode
      busCycle(32'h3FC, 32'h55, 1'b1);
      busCycle(32'h408, 32'h55, 1'b1);
      busCycle(32'h500, 32'h0, 1'b0);
      repeat (4) idle();
      checkVal("decode_tx", {31'b0, tx}, 32'h1);
      checkVal("decode_busy", {31'b0, busy}, 32'h0);
      A = 32'h500; WE = 1'b0;
      #1;
      checkVal("decode_rd500", RD, 32'h0);
      busCycle(32'h402, 32'h3C, 1'b1);
      idle();
      checkVal("decode_402", {31'b0, tx}, 32'h0);
      repeat (45) idle();

      // reset mid-frame during data bit 3 with two bytes queued
      busCycle(32'h400, 32'hF7, 1'b1);
      busCycle(32'h400, 32'h11, 1'b1);
      busCycle(32'h400, 32'h22, 1'b1);
      repeat (16) idle();
      checkVal("midrst_pre", {31'b0, tx}, 32'h0);
      reset = 1'b0;
      #1;
      checkVal("midrst_tx", {31'b0, tx}, 32'h1);
      checkVal("midrst_busy", {31'b0, busy}, 32'h0);
      modelReset();
      repeat (3) busCycle(randAddr(), $urandom, 1'($urandom));
      reset = 1'b1;
      readStatus("midrst_status", 32'h1);
      repeat (50) idle();

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         int r;
         r = $urandom_range(0, 199);
         if (r < 24)      busCycle(32'h400 | $urandom_range(0, 3), $urandom, 1'b1);
         else if (r < 30) busCycle(32'h404 | $urandom_range(0, 3), $urandom, 1'b1);
         else if (r < 40) busCycle(randAddr(), $urandom, 1'b1);
         else if (r == 199) begin
            reset = 1'b0;
            #1;
            checkVal("rnd_rst_tx", {31'b0, tx}, 32'h1);
            modelReset();
            busCycle(randAddr(), $urandom, 1'($urandom));
            reset = 1'b1;
         end
         else idle();
      end
      repeat (500) idle();
      readStatus("final_status", expRd(32'h404));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter on the ARMv4 data-memory bus, in parallel with the data memory. It consumes the processor's store traffic (address, write data, write enable) and serialises bytes written to its data register as 8N1 frames on `tx`. An 8-entry byte FIFO decouples single-cycle stores from the slow serial line. A status register returns the FIFO and line state to processor loads.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per serial bit (50 MHz / 115200); minimum 2
- `FIFO_DEPTH`, 8, byte FIFO entries; power of two
- `BASE_ADDR`, 32'h0000_0400, word-aligned base address of the register window

- `clk`  in  1  system clock, rising-edge
- `reset`  in  1  asynchronous, active-low reset
- `A`  in  32  data-bus address from processor (`AddressDataMem`)
- `WD`  in  32  data-bus write data (`WriteDataMem`)
- `WE`  in  1  data-bus write enable (`WriteEnableMem`)
- `RD`  out  32  register read data, combinational from `A`
- `tx`  out  1  serial output, idle high
- `busy`  out  1  FIFO non-empty or frame in progress

## Operation
- Decode on `A[31:2]` only; `A[1:0]` ignored.
- TXDATA at `BASE_ADDR+0`:
  - Write pushes `WD[7:0]`; `WD[31:8]` ignored.
  - Read returns 0.
- STATUS at `BASE_ADDR+4`:
  - Read returns `{28'b0, overflow, busy, full, empty}`.
  - Write with `WD[3]=1` clears `overflow`; other write bits are ignored.
- `RD`:
  - Equals 0 for any address outside the window.
  - Depends only on `A` and internal state, never on `WE`.
- FIFO:
  - `empty` when count==0, `full` when count==`FIFO_DEPTH`.
  - A push while `full` is dropped and sets sticky `overflow`, even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full: both take effect and the count is unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- FSM states IDLE, START, DATA, STOP; `tx` is 1 in IDLE, 0 in START, shift[0] in DATA, 1 in STOP.
  - IDLE→START: at an edge where the FIFO is non-empty. The head is popped into the 8-bit shift register and the bit counter cleared.
  - START→DATA: after `CLKS_PER_BIT` cycles.
  - DATA: each `CLKS_PER_BIT` cycles the register shifts right and the bit index increments. After bit 7 completes → STOP. Data is sent LSB first.
  - STOP→IDLE: after `CLKS_PER_BIT` cycles, always via IDLE.
- Baud counter: 0..`CLKS_PER_BIT`-1, reset on every state change. Width is $clog2(`CLKS_PER_BIT`).
- `busy` = (state != IDLE) | !empty.

## Timing
- Reset asserted (`reset`=0), asynchronously:
  - `tx`=1, state IDLE, FIFO empty (pointers and count 0), `overflow`=0, `busy`=0, shift register 0.
  - A frame in progress is aborted immediately, with no stop bit. Queued bytes are lost.
- Reset release: the first active edge is the first edge with `reset`=1.
- Store at edge N:
  - FIFO count updates after N.
  - If IDLE at edge N+1, the pop happens there and `tx` falls after N+1.
  - Write-to-start-bit latency is 1 cycle.
- Frame length: exactly 10×`CLKS_PER_BIT` cycles from `tx` falling to STOP exit.
- Back-to-back bytes: exactly one IDLE cycle (`tx`=1) between the stop bit and the next start bit.
- STATUS reads reflect state registered at the previous edge. A push at edge N is visible in `empty` from N onward.
- `overflow` set and clear in the same cycle: set wins.

## Test plan
- Reset: hold `reset`=0 for 3 cycles with random bus activity → `tx`=1, `busy`=0; STATUS read = 32'h1.
- Single byte (`CLKS_PER_BIT`=4), write 0xA5 to 0x400:
  - `tx` low 1 cycle after the write edge.
  - Then 4-cycle bits 0,1,0,1,0,0,1,0,1,1.
  - `busy` drops 40 cycles after `tx` falls.
- Overflow: 10 consecutive writes 0x01..0x0A while idle:
  - After the tenth, STATUS = 32'hE (overflow, busy, full).
  - Bytes 0x01..0x09 are transmitted; 0x0A never is.
  - Writing 0x8 to 0x404 → `overflow`=0.
- Back-to-back: write 0x00 then 0xFF → exactly one idle-high cycle between the first stop bit and the second start bit; frames are bit-exact.
- Decode: write 0x55 to 0x3FC and 0x408, and read 0x500 → no frame, `RD`=0. Write to 0x402 → treated as TXDATA.
- Reset mid-frame: assert `reset` during DATA bit 3 with 2 bytes queued → `tx`=1 immediately; after release STATUS=32'h1 and no transmission.
